data_memory: RTL and testbench
==============================

# data_memory

Multi-cycle main-memory responder on the far end of the core's word-wide memory port: serves the `mem_addr` / `mem_data_in` / `mem_write_en` requests issued by the core's cache and returns `mem_data_out` plus a completion strobe. Models a fixed access latency so cache miss-handling and write-back timing are exercised realistically. Sits outside `mips_core`, instantiated beside it in the machine top level and in benches.

## Interface
- `ADDR_BITS`, default 16: log2 of storage size in bytes. Storage holds 2^ADDR_BITS bytes.
- `LATENCY`, default 4: cycles from request capture to completion. Legal range is 1..255.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_b` input, 1 bit: reset, asynchronous, active-low.
- `mem_addr` input, 32 bits: byte address. Bits [1:0] and [31:ADDR_BITS] are ignored.
- `mem_data_in` input, 8 bits x 4 (`[0:3]`): write bytes. Element 0 goes to word base +0.
- `mem_write_en` input, 1 bit: 1 selects a write, 0 selects a read.
- `mem_data_out` output, 8 bits x 4 (`[0:3]`): registered read data. Element 0 comes from word base +0.
- `mem_ready` output, 1 bit: access complete. Held high while the request stays unchanged.

## Operation
- Registers:
  - `last_addr`, `last_we`, `last_data`: the previous cycle's inputs.
  - `cnt`: 8-bit counter.
  - `state`: one of IDLE, WAIT, DONE.
  - `mem_ready`, `mem_data_out`.
  - Byte array `mem[0:2^ADDR_BITS-1]`.
- Word index is `mem_addr[ADDR_BITS-1:2]`.
  - Upper address bits are dropped, so the address space wraps modulo 2^ADDR_BITS.
  - Low two bits are dropped, so every access is word-aligned.
- `changed` is 1 when any of these differ from the previous cycle:
  - `mem_addr[ADDR_BITS-1:2]` vs `last_addr`
  - `mem_write_en` vs `last_we`
  - `mem_data_in` vs `last_data`, compared only while `mem_write_en`=1
- At every rising edge, `last_*` registers load the current inputs.
- State transitions, evaluated in priority order at each rising edge:
  - State is IDLE, or `changed`=1: go to WAIT; `cnt`<=1; `mem_ready`<=0; no array access.
  - WAIT and `cnt`!=LATENCY: `cnt`<=`cnt`+1.
  - WAIT and `cnt`==LATENCY: perform the access; `mem_ready`<=1; go to DONE.
    - Read: `mem_data_out[i]`<=`mem[base+i]`.
    - Write: `mem[base+i]`<=`mem_data_in[i]`, and `mem_data_out[i]`<=`mem_data_in[i]` (write readback).
  - DONE and unchanged: hold all state. A write is never repeated.
- Reset values:
  - `state`=IDLE, `cnt`=0, `mem_ready`=0.
  - `mem_data_out` all bytes 0x00.
  - `last_*` all 0.
  - The storage array is NOT cleared. Benches preload it by backdoor.
- Request changes while in WAIT or DONE restart the access. An in-flight write that is abandoned never reaches the array.
- A reset asserted mid-WAIT aborts the access: no write, and outputs go to reset values immediately (asynchronous).
- `mem_data_out` only updates at completion. Between completions it holds the last completed value, including while `mem_ready`=0.

## Timing
- The request is presented in cycle n and sampled at edge n.
- `mem_ready`=1 and valid `mem_data_out` appear from cycle n+LATENCY+1.
  - With LATENCY=4: sampled at edge n, completes at edge n+4.
- `mem_ready` falls one cycle after any input change, because the change is seen at the next edge.
- The first edge after reset release is always treated as a new request, even if inputs are all zero.
- The array write occurs at exactly one edge per completed write request.
- Back-to-back requests: a change in the same cycle `mem_ready` rises is captured normally. The new request completes LATENCY+1 cycles after that edge.

## Test plan
- **Reset then read.** Preload word 0x0010 = {0xDE,0xAD,0xBE,0xEF}. Drive addr 0x10, we=0 from the first cycle after `rst_b` rises. Expect `mem_ready`=0 through 4 edges, then 1 with `mem_data_out`={DE,AD,BE,EF}.
- **Write then read back.** Write {11,22,33,44} to 0x20 and hold it until ready. Expect `mem_data_out`={11,22,33,44} at completion. Switch to a read of 0x20: expect ready to drop, then return after 5 edges with the same data.
- **Abort.** Write {AA,BB,CC,DD} to 0x30, over old contents {01,02,03,04}. Change addr to 0x34 after 2 cycles, with we=0. Read 0x30 afterwards: expect {01,02,03,04}, i.e. the aborted write never landed.
- **No repeated write.** Complete a write of {55,..} to 0x40 and hold the request 10 cycles in DONE. Backdoor-poke 0x40 = {00,..} during the hold. Expect the array to stay {00,..}.
- **Reset mid-operation.** Assert `rst_b`=0 asynchronously during WAIT of a write. Expect `mem_ready`=0 and `mem_data_out`=0 immediately, and the target word unchanged.
- **Wrap and alignment.** With ADDR_BITS=16, write {9A,..} to 0xFFFF_FFFE. Then read 0x0000_FFFC. Expect {9A,..}.

Source files
------------

// File: rtl/data_memory.sv
// Word-wide main-memory responder with a fixed access latency.
// A request must stay stable for LATENCY+1 edges to complete. Any change to the request restarts it.
module data_memory #(
  parameter int ADDR_BITS = 16,
  parameter int LATENCY   = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [31:0]     mem_addr,
  input  logic [0:3][7:0] mem_data_in,
  input  logic            mem_write_en,
  output logic [0:3][7:0] mem_data_out,
  output logic            mem_ready
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                 state, state_nxt;
  logic [7:0]             cnt, cnt_nxt;
  logic                   ready_nxt;
  logic                   access;
  logic                   changed;

  logic [ADDR_BITS-3:0]   word, last_addr;
  logic                   last_we;
  logic [0:3][7:0]        last_data;
  logic [ADDR_BITS-1:0]   base;

  logic [7:0]             mem [0:(2**ADDR_BITS)-1];

  logic                   unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_BITS], mem_addr[1:0]};

  assign word = mem_addr[ADDR_BITS-1:2];
  assign base = {word, 2'b00};

  // Write data counts as a change only when the request is a write.
  assign changed = (word != last_addr) || (mem_write_en != last_we) ||
                   (mem_write_en && (mem_data_in != last_data));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_nxt = mem_ready;
    access    = 1'b0;
    if (state == IDLE || changed) begin
      state_nxt = WAIT;
      cnt_nxt   = 8'd1;
      ready_nxt = 1'b0;
    end else if (state == WAIT) begin
      if (cnt != 8'(LATENCY)) begin
        cnt_nxt = cnt + 8'd1;
      end else begin
        access    = 1'b1;
        ready_nxt = 1'b1;
        state_nxt = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      mem_ready    <= 1'b0;
      mem_data_out <= '0;
      last_addr    <= '0;
      last_we      <= 1'b0;
      last_data    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_ready <= ready_nxt;
      last_addr <= word;
      last_we   <= mem_write_en;
      last_data <= mem_data_in;
      if (access) begin
        for (int i = 0; i < 4; i++) begin
          mem_data_out[i] <= mem_write_en ? mem_data_in[i] : mem[base + ADDR_BITS'(i)];
        end
      end
    end
  end

  // Storage is deliberately not reset. The access strobe is already low while reset is held.
  always_ff @(posedge clk) begin
    if (access && mem_write_en) begin
      for (int i = 0; i < 4; i++) begin
        mem[base + ADDR_BITS'(i)] <= mem_data_in[i];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory.
// Expected completion data is queued when a request is driven, and compared when mem_ready rises.
module tb_data_memory;
  localparam int LAT = 4;

  logic            clk = 1'b0;
  logic            rst_b = 1'b0;
  logic [31:0]     mem_addr = '0;
  logic [0:3][7:0] mem_data_in = '0;
  logic            mem_write_en = 1'b0;
  logic [0:3][7:0] mem_data_out;
  logic            mem_ready;

  int vectors = 0;
  int errors  = 0;
  logic [0:3][7:0] exp_q[$];

  data_memory #(.ADDR_BITS(16), .LATENCY(LAT)) dut (
    .clk(clk), .rst_b(rst_b), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .mem_data_out(mem_data_out), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [0:3][7:0] d);
    for (int i = 0; i < 4; i++) dut.mem[a + 16'(i)] = d[i];
  endtask

  task automatic peek(input logic [15:0] a, output logic [0:3][7:0] d);
    for (int i = 0; i < 4; i++) d[i] = dut.mem[a + 16'(i)];
  endtask

  // Drive a request, then wait for completion. Checks the latency and the completed data.
  task automatic do_req(input logic [31:0] a, input logic we, input logic [0:3][7:0] d,
                        input logic [0:3][7:0] exp, input string name);
    int n;
    bit got;
    logic [0:3][7:0] e;
    mem_addr = a; mem_write_en = we; mem_data_in = d;
    exp_q.push_back(exp);
    n = 0; got = 0;
    while (!got && n < 30) begin
      step();
      n++;
      if (mem_ready === 1'b1) got = 1;
    end
    e = exp_q.pop_front();
    vectors++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: ready=%b after %0d cycles, required ready=1", name, mem_ready, n);
    end else begin
      if (n !== LAT + 1) begin
        errors++;
        $display("FAIL %s latency: got %0d edges, required %0d", name, n, LAT + 1);
      end
      vectors++;
      if (mem_data_out !== e) begin
        errors++;
        $display("FAIL %s data: got %h, required %h", name, mem_data_out, e);
      end
    end
  endtask

  task automatic test_reset();
    int n;
    poke(16'h0010, 32'hDEADBEEF);
    step(); step();
    vectors++;
    if (mem_ready !== 1'b0 || mem_data_out !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%b data=%h, required 0 / 00000000", mem_ready, mem_data_out);
    end
    rst_b = 1'b1;
    do_req(32'h10, 1'b0, '0, 32'hDEADBEEF, "reset_then_read");
  endtask

  task automatic test_write_read();
    do_req(32'h20, 1'b1, 32'h11223344, 32'h11223344, "write_20");
    step();
    do_req(32'h20, 1'b0, 32'h11223344, 32'h11223344, "readback_20");
  endtask

  task automatic test_abort();
    logic [0:3][7:0] m;
    poke(16'h0030, 32'h01020304);
    poke(16'h0034, 32'h5A6B7C8D);
    mem_addr = 32'h30; mem_write_en = 1'b1; mem_data_in = 32'hAABBCCDD;
    step(); step();
    vectors++;
    if (mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready: got %b, required 0", mem_ready);
    end
    do_req(32'h34, 1'b0, 32'hAABBCCDD, 32'h5A6B7C8D, "abort_redirect_34");
    do_req(32'h30, 1'b0, 32'hAABBCCDD, 32'h01020304, "abort_read_30");
    peek(16'h0030, m);
    vectors++;
    if (m !== 32'h01020304) begin
      errors++;
      $display("FAIL abort_array: got %h, required 01020304", m);
    end
  endtask

  task automatic test_no_repeat();
    logic [0:3][7:0] m;
    do_req(32'h40, 1'b1, 32'h55555555, 32'h55555555, "write_40");
    poke(16'h0040, 32'h00000000);
    repeat (10) step();
    peek(16'h0040, m);
    vectors++;
    if (m !== 32'h00000000) begin
      errors++;
      $display("FAIL no_repeat_array: got %h, required 00000000", m);
    end
    vectors++;
    if (mem_ready !== 1'b1 || mem_data_out !== 32'h55555555) begin
      errors++;
      $display("FAIL no_repeat_hold: ready=%b data=%h, required 1 / 55555555", mem_ready, mem_data_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [0:3][7:0] m;
    poke(16'h0050, 32'h12345678);
    mem_addr = 32'h50; mem_write_en = 1'b1; mem_data_in = 32'hFFFFFFFF;
    step(); step();
    #2 rst_b = 1'b0;
    #1;
    vectors++;
    if (mem_ready !== 1'b0 || mem_data_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: ready=%b data=%h, required 0 / 00000000", mem_ready, mem_data_out);
    end
    step(); step();
    peek(16'h0050, m);
    vectors++;
    if (m !== 32'h12345678) begin
      errors++;
      $display("FAIL reset_mid_array: got %h, required 12345678", m);
    end
    mem_write_en = 1'b0;
    rst_b = 1'b1;
    do_req(32'h50, 1'b0, 32'hFFFFFFFF, 32'h12345678, "reset_mid_read_50");
  endtask

  task automatic test_wrap();
    logic [0:3][7:0] m;
    do_req(32'hFFFF_FFFE, 1'b1, 32'h9A9B9C9D, 32'h9A9B9C9D, "wrap_write");
    peek(16'hFFFC, m);
    vectors++;
    if (m !== 32'h9A9B9C9D) begin
      errors++;
      $display("FAIL wrap_array: got %h, required 9a9b9c9d", m);
    end
    do_req(32'h0000_FFFC, 1'b0, '0, 32'h9A9B9C9D, "wrap_read");
  endtask

  task automatic test_back_to_back();
    poke(16'h0100, 32'hC0FFEE01);
    poke(16'h0104, 32'hBADC0DE2);
    do_req(32'h100, 1'b0, '0, 32'hC0FFEE01, "b2b_0");
    do_req(32'h104, 1'b0, '0, 32'hBADC0DE2, "b2b_1");
    do_req(32'h101, 1'b1, 32'h0A0B0C0D, 32'h0A0B0C0D, "b2b_write");
    do_req(32'h100, 1'b0, '0, 32'h0A0B0C0D, "b2b_readback");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_abort();
    test_no_repeat();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
